// File: rtl/irq_pkg.sv
// Shared constants for the interrupt sequencer: source count, FSM encoding
// and the default entrance vectors.
package irq_pkg;

    localparam int NUM_SRC = 3;

    typedef logic [NUM_SRC-1:0] src_vec_t;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_REQ  = 2'd1;
    localparam logic [1:0] ST_ISR  = 2'd2;

    localparam logic [31:0] VEC0_DEF = 32'h0000_0800;
    localparam logic [31:0] VEC1_DEF = 32'h0000_0600;
    localparam logic [31:0] VEC2_DEF = 32'h0000_0000;

    function automatic src_vec_t idx_onehot(input logic [1:0] idx);
        src_vec_t oh;
        oh = '0;
        case (idx)
            2'd0:    oh = 3'b001;
            2'd1:    oh = 3'b010;
            2'd2:    oh = 3'b100;
            default: oh = '0;
        endcase
        return oh;
    endfunction

endpackage

// File: rtl/irq_prio_enc.sv
// Highest-set-bit priority encoder for the three interrupt sources.
module irq_prio_enc
    import irq_pkg::*;
(
    input  logic [NUM_SRC-1:0] vec_i,
    output logic               valid_o,
    output logic [1:0]         idx_o
);

    always_comb begin
        valid_o = |vec_i;
        idx_o   = 2'd0;
        if (vec_i[2]) begin
            idx_o = 2'd2;
        end else if (vec_i[1]) begin
            idx_o = 2'd1;
        end
    end

endmodule

// File: rtl/irq_sequencer.sv
// Edge-latched, priority-ordered interrupt request sequencer for a CPU core.
// Optional nesting of higher-priority sources during service: IRQ_NEST_EN.
//
//   state | meaning
//   IDLE  | nothing in service, no request outstanding
//   REQ   | irq_req asserted, irq_id frozen until ack or drop
//   ISR   | at least one source in service, no request outstanding
module irq_sequencer
    import irq_pkg::*;
#(
    parameter logic [31:0] VEC0 = VEC0_DEF,
    parameter logic [31:0] VEC1 = VEC1_DEF,
    parameter logic [31:0] VEC2 = VEC2_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_SRC-1:0] irq_src,
    input  logic [NUM_SRC-1:0] irq_mask,
    input  logic               irq_disable,
    input  logic               irq_ack,
    input  logic               eret,
    output logic               irq_req,
    output logic [1:0]         irq_id,
    output logic [31:0]        irq_vec,
    output logic [NUM_SRC-1:0] pending,
    output logic [NUM_SRC-1:0] in_service
);

    logic [1:0]   state_q, state_d;
    logic         irq_req_q, irq_req_d;
    logic [1:0]   irq_id_q, irq_id_d;
    src_vec_t     pending_q, pending_d;
    src_vec_t     in_service_q, in_service_d;
    src_vec_t     prev_q, prev_d;

    src_vec_t     edge_w;
    src_vec_t     id_oh;
    src_vec_t     eligible;
    src_vec_t     is_after_ack;
    src_vec_t     eret_clr;
    logic         ack_fire;
    logic         el_valid;
    logic [1:0]   el_idx;
    logic         is_valid;
    logic [1:0]   is_top;

    always_comb begin
        edge_w       = irq_src & ~prev_q;
        prev_d       = irq_src;
        id_oh        = idx_onehot(irq_id_q);
        eligible     = pending_q & irq_mask;
        ack_fire     = (state_q == ST_REQ) && irq_ack;
        is_after_ack = in_service_q | (ack_fire ? id_oh : '0);
    end

    irq_prio_enc u_enc_eligible (
        .vec_i   (eligible),
        .valid_o (el_valid),
        .idx_o   (el_idx)
    );

    // Looks at in_service after the ack is applied, so ack+eret retires the right bit.
    irq_prio_enc u_enc_in_service (
        .vec_i   (is_after_ack),
        .valid_o (is_valid),
        .idx_o   (is_top)
    );

    always_comb begin
        state_d  = state_q;
        irq_id_d = irq_id_q;
        eret_clr = (eret && is_valid) ? idx_onehot(is_top) : '0;

        // Edge is OR-ed after the ack clear so a coincident edge keeps the bit set.
        pending_d    = (pending_q & ~(ack_fire ? id_oh : '0)) | edge_w;
        in_service_d = is_after_ack & ~eret_clr;

        case (state_q)
            ST_IDLE: begin
                if (el_valid && !irq_disable) begin
                    state_d  = ST_REQ;
                    irq_id_d = el_idx;
                end
            end
            ST_REQ: begin
                if (ack_fire) begin
                    state_d = (in_service_d != '0) ? ST_ISR : ST_IDLE;
                end else if (irq_disable || ((pending_q & irq_mask & id_oh) == '0)) begin
                    state_d = (in_service_d != '0) ? ST_ISR : ST_IDLE;
                end
            end
            ST_ISR: begin
                if (in_service_d == '0) begin
                    state_d = ST_IDLE;
`ifdef IRQ_NEST_EN
                end else if (!irq_disable && el_valid && (el_idx > is_top)) begin
                    state_d  = ST_REQ;
                    irq_id_d = el_idx;
`endif
                end
            end
            default: state_d = ST_IDLE;
        endcase

        irq_req_d = (state_d == ST_REQ);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            irq_req_q    <= 1'b0;
            irq_id_q     <= 2'd0;
            pending_q    <= '0;
            in_service_q <= '0;
            prev_q       <= '1;
        end else begin
            state_q      <= state_d;
            irq_req_q    <= irq_req_d;
            irq_id_q     <= irq_id_d;
            pending_q    <= pending_d;
            in_service_q <= in_service_d;
            prev_q       <= prev_d;
        end
    end

    always_comb begin
        irq_vec = 32'h0;
        if (irq_req_q) begin
            case (irq_id_q)
                2'd0:    irq_vec = VEC0;
                2'd1:    irq_vec = VEC1;
                2'd2:    irq_vec = VEC2;
                default: irq_vec = 32'h0;
            endcase
        end
    end

    assign irq_req    = irq_req_q;
    assign irq_id     = irq_id_q;
    assign pending    = pending_q;
    assign in_service = in_service_q;

endmodule

// File: tb/tb_irq_sequencer.sv
// Directed bench for irq_sequencer: a cycle-by-cycle vector table plus
// hand-written sequences for nesting, reset and coincident-event corners.
module tb_irq_sequencer;

    logic        clk;
    logic        rst;
    logic [2:0]  irq_src;
    logic [2:0]  irq_mask;
    logic        irq_disable;
    logic        irq_ack;
    logic        eret;
    logic        irq_req;
    logic [1:0]  irq_id;
    logic [31:0] irq_vec;
    logic [2:0]  pending;
    logic [2:0]  in_service;

    int tests_run = 0;
    int tests_failed = 0;

    irq_sequencer dut (
        .clk         (clk),
        .rst         (rst),
        .irq_src     (irq_src),
        .irq_mask    (irq_mask),
        .irq_disable (irq_disable),
        .irq_ack     (irq_ack),
        .eret        (eret),
        .irq_req     (irq_req),
        .irq_id      (irq_id),
        .irq_vec     (irq_vec),
        .pending     (pending),
        .in_service  (in_service)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  src;
        logic [2:0]  mask;
        logic        dis;
        logic        ack;
        logic        eret;
        logic        exp_req;
        logic [1:0]  exp_id;
        logic [31:0] exp_vec;
        logic [2:0]  exp_pend;
        logic [2:0]  exp_is;
    } vec_t;

    vec_t tbl[$];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [2:0] s, input logic [2:0] m, input logic d,
                         input logic a, input logic e);
        irq_src     = s;
        irq_mask    = m;
        irq_disable = d;
        irq_ack     = a;
        eret        = e;
    endtask

    task automatic check_outs(input string tag, input logic r, input logic [1:0] id,
                              input logic [31:0] v, input logic [2:0] p, input logic [2:0] is);
        check({tag, ".req"}, {31'h0, irq_req}, {31'h0, r});
        check({tag, ".vec"}, irq_vec, v);
        check({tag, ".pend"}, {29'h0, pending}, {29'h0, p});
        check({tag, ".is"}, {29'h0, in_service}, {29'h0, is});
        if (r) check({tag, ".id"}, {30'h0, irq_id}, {30'h0, id});
    endtask

    // Reset with all lines low, then one quiet cycle so prev settles to 0.
    task automatic do_reset();
        drive(3'b000, 3'b111, 1'b0, 1'b0, 1'b0);
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        tick();
    endtask

    initial begin
        rst = 1'b1;
        drive(3'b000, 3'b111, 1'b0, 1'b0, 1'b0);

        //                src     mask    dis   ack   eret  req  id     vec            pend    is
        tbl.push_back('{3'b001, 3'b111, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 32'h0,        3'b001, 3'b000});
        tbl.push_back('{3'b001, 3'b111, 1'b0, 1'b0, 1'b0, 1'b1, 2'd0, 32'h0000_0800, 3'b001, 3'b000});
        tbl.push_back('{3'b001, 3'b111, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 32'h0,        3'b000, 3'b001});
        tbl.push_back('{3'b001, 3'b111, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 32'h0,        3'b000, 3'b000});
        tbl.push_back('{3'b000, 3'b111, 1'b0, 1'b1, 1'b1, 1'b0, 2'd0, 32'h0,        3'b000, 3'b000});
        tbl.push_back('{3'b101, 3'b111, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 32'h0,        3'b101, 3'b000});
        tbl.push_back('{3'b101, 3'b111, 1'b0, 1'b0, 1'b0, 1'b1, 2'd2, 32'h0,        3'b101, 3'b000});
        tbl.push_back('{3'b101, 3'b111, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 32'h0,        3'b001, 3'b100});
        tbl.push_back('{3'b101, 3'b111, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 32'h0,        3'b001, 3'b000});
        tbl.push_back('{3'b101, 3'b111, 1'b0, 1'b0, 1'b0, 1'b1, 2'd0, 32'h0000_0800, 3'b001, 3'b000});
        tbl.push_back('{3'b101, 3'b111, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 32'h0,        3'b000, 3'b001});
        tbl.push_back('{3'b101, 3'b111, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 32'h0,        3'b000, 3'b000});
        tbl.push_back('{3'b111, 3'b111, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 32'h0,        3'b010, 3'b000});
        tbl.push_back('{3'b111, 3'b111, 1'b0, 1'b0, 1'b0, 1'b1, 2'd1, 32'h0000_0600, 3'b010, 3'b000});
        tbl.push_back('{3'b111, 3'b111, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 32'h0,        3'b010, 3'b000});
        tbl.push_back('{3'b111, 3'b111, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 32'h0,        3'b010, 3'b000});
        tbl.push_back('{3'b111, 3'b111, 1'b0, 1'b0, 1'b0, 1'b1, 2'd1, 32'h0000_0600, 3'b010, 3'b000});
        tbl.push_back('{3'b111, 3'b111, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 32'h0,        3'b000, 3'b010});
        tbl.push_back('{3'b111, 3'b111, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 32'h0,        3'b000, 3'b000});
        tbl.push_back('{3'b000, 3'b111, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 32'h0,        3'b000, 3'b000});
        tbl.push_back('{3'b001, 3'b110, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 32'h0,        3'b001, 3'b000});
        tbl.push_back('{3'b001, 3'b110, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 32'h0,        3'b001, 3'b000});
        tbl.push_back('{3'b001, 3'b111, 1'b0, 1'b0, 1'b0, 1'b1, 2'd0, 32'h0000_0800, 3'b001, 3'b000});
        tbl.push_back('{3'b001, 3'b110, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 32'h0,        3'b001, 3'b000});
        tbl.push_back('{3'b001, 3'b111, 1'b0, 1'b0, 1'b0, 1'b1, 2'd0, 32'h0000_0800, 3'b001, 3'b000});
        tbl.push_back('{3'b001, 3'b111, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 32'h0,        3'b000, 3'b001});
        tbl.push_back('{3'b001, 3'b111, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 32'h0,        3'b000, 3'b000});

        do_reset();
        check_outs("reset", 1'b0, 2'd0, 32'h0, 3'b000, 3'b000);

        for (int i = 0; i < tbl.size(); i++) begin
            drive(tbl[i].src, tbl[i].mask, tbl[i].dis, tbl[i].ack, tbl[i].eret);
            tick();
            check_outs($sformatf("row%0d", i), tbl[i].exp_req, tbl[i].exp_id,
                       tbl[i].exp_vec, tbl[i].exp_pend, tbl[i].exp_is);
        end

        // Higher-priority source arriving while source 0 is in service.
        do_reset();
        drive(3'b001, 3'b111, 1'b0, 1'b0, 1'b0); tick(); tick();
        irq_ack = 1'b1; tick(); irq_ack = 1'b0;
        check_outs("nest.isr0", 1'b0, 2'd0, 32'h0, 3'b000, 3'b001);
        irq_src = 3'b101; tick();
        check_outs("nest.edge2", 1'b0, 2'd0, 32'h0, 3'b100, 3'b001);
        tick();
`ifdef IRQ_NEST_EN
        check_outs("nest.req2", 1'b1, 2'd2, 32'h0, 3'b100, 3'b001);
        irq_ack = 1'b1; tick(); irq_ack = 1'b0;
        check_outs("nest.ack2", 1'b0, 2'd0, 32'h0, 3'b000, 3'b101);
        eret = 1'b1; tick();
        check_outs("nest.eret2", 1'b0, 2'd0, 32'h0, 3'b000, 3'b001);
        tick(); eret = 1'b0;
        check_outs("nest.eret0", 1'b0, 2'd0, 32'h0, 3'b000, 3'b000);
`else
        check_outs("nonest.hold", 1'b0, 2'd0, 32'h0, 3'b100, 3'b001);
        eret = 1'b1; tick(); eret = 1'b0;
        check_outs("nonest.eret0", 1'b0, 2'd0, 32'h0, 3'b100, 3'b000);
        tick();
        check_outs("nonest.req2", 1'b1, 2'd2, 32'h0, 3'b100, 3'b000);
        irq_ack = 1'b1; tick(); irq_ack = 1'b0;
        check_outs("nonest.ack2", 1'b0, 2'd0, 32'h0, 3'b000, 3'b100);
`endif

        // Line already high when reset releases is not an edge.
        drive(3'b111, 3'b111, 1'b0, 1'b0, 1'b0);
        rst = 1'b1; tick(); tick(); rst = 1'b0;
        tick();
        check_outs("hold.rel", 1'b0, 2'd0, 32'h0, 3'b000, 3'b000);
        tick();
        check_outs("hold.rel2", 1'b0, 2'd0, 32'h0, 3'b000, 3'b000);
        irq_src = 3'b101; tick();
        check_outs("hold.fall", 1'b0, 2'd0, 32'h0, 3'b000, 3'b000);
        irq_src = 3'b111; tick();
        check_outs("hold.rise", 1'b0, 2'd0, 32'h0, 3'b010, 3'b000);

        // Ack coincides with a fresh edge on the acknowledged source.
        do_reset();
        irq_src = 3'b001; tick();
        irq_src = 3'b000; tick();
        check_outs("ackedge.req", 1'b1, 2'd0, 32'h0000_0800, 3'b001, 3'b000);
        irq_src = 3'b001; irq_ack = 1'b1; tick(); irq_ack = 1'b0;
        check_outs("ackedge.ack", 1'b0, 2'd0, 32'h0, 3'b001, 3'b001);

        // Ack and eret in the same cycle: the just-acked source retires at once.
        do_reset();
        irq_src = 3'b001; tick(); tick();
        irq_ack = 1'b1; eret = 1'b1; tick(); irq_ack = 1'b0; eret = 1'b0;
        check_outs("ackeret", 1'b0, 2'd0, 32'h0, 3'b000, 3'b000);
        tick();
        check_outs("ackeret.idle", 1'b0, 2'd0, 32'h0, 3'b000, 3'b000);

        // Reset during REQ abandons the request without ack side effects.
        do_reset();
        irq_src = 3'b010; tick(); tick();
        check_outs("rstreq.req", 1'b1, 2'd1, 32'h0000_0600, 3'b010, 3'b000);
        rst = 1'b1; irq_ack = 1'b1; tick(); rst = 1'b0; irq_ack = 1'b0;
        check_outs("rstreq.rst", 1'b0, 2'd0, 32'h0, 3'b000, 3'b000);
        tick();
        check_outs("rstreq.after", 1'b0, 2'd0, 32'h0, 3'b000, 3'b000);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/irq_sequencer.md
IRQ_SEQUENCER -- requirements
Module: irq_sequencer

Interface
REQ-001 Parameter VEC0, 32'h0000_0800, entrance address for source 0 (lowest priority).
REQ-002 Parameter VEC1, 32'h0000_0600, entrance address for source 1.
REQ-003 Parameter VEC2, 32'h0000_0000, entrance address for source 2 (highest priority).
REQ-004 clk  in  1  single clock; all state SHALL update on its rising edge.
REQ-005 rst  in  1  synchronous, active-high reset.
REQ-006 irq_src  in  3  raw interrupt lines, synchronous to clk, rising-edge triggered.
REQ-007 irq_mask  in  3  per-source enable; 1 = enabled.
REQ-008 irq_disable  in  1  global interrupt disable (CP0 reg 0x16).
REQ-009 irq_ack  in  1  CPU took the request this cycle (PC redirected, EPC written).
REQ-010 eret  in  1  exception-return instruction retiring this cycle.
REQ-011 irq_req  out  1  request to CPU, registered.
REQ-012 irq_id  out  2  granted source index, valid while irq_req=1.
REQ-013 irq_vec  out  32  entrance address for irq_id, valid while irq_req=1, else 0.
REQ-014 pending  out  3  latched, not-yet-acknowledged edges.
REQ-015 in_service  out  3  acknowledged, not-yet-returned sources.

Function
REQ-016 Edge detect: edge[i] = irq_src[i] & ~prev[i]; prev updates every cycle.
REQ-017 pending[i] SHALL set on the clk edge where edge[i]=1; a source with a set pending bit SHALL NOT queue further edges.
REQ-018 eligible = pending & irq_mask. Winner is the highest set index of eligible.
REQ-019 FSM states: IDLE (in_service=0, no request), REQ (irq_req=1), ISR (in_service!=0, no request).
REQ-020 IDLE->REQ when eligible!=0 and irq_disable=0. irq_id SHALL latch the winner. Latency is 2 cycles from the first edge where the line is sampled high.
REQ-021 In REQ, irq_id SHALL stay frozen. On irq_ack: clear pending[id] and set in_service[id], then go to ISR.
REQ-022 In REQ without ack: if irq_disable=1 or pending[id]&irq_mask[id]=0, drop irq_req next cycle. Return to ISR if in_service!=0, else IDLE.
REQ-023 eret: clear the highest set in_service bit. In ISR with a resulting in_service of 0, go to IDLE. In REQ, stay in REQ.
REQ-024 eret with in_service=0 SHALL be ignored. irq_ack outside REQ SHALL be ignored.
REQ-025 Simultaneous ack-clear and new edge on the same source: the edge wins and pending stays 1.
REQ-026 Simultaneous irq_ack and eret: the ack is applied first, then eret clears the highest in_service bit.
REQ-027 irq_vec SHALL be the combinational lookup VEC[irq_id] gated by irq_req.

Reset
REQ-028 On rst: state=IDLE; irq_req, irq_id, pending and in_service = 0; prev=3'b111, so lines already high at reset release are not edges.
REQ-029 rst asserted mid-REQ or mid-ISR SHALL abandon the request/service with no ack/eret side effects.

Configuration
REQ-030 Macro IRQ_NEST_EN. When defined: ISR->REQ is allowed when irq_disable=0 and the eligible winner index > highest in_service index. When undefined: REQ is entered only from IDLE, and sources pend until in_service=0.

Structure
REQ-031 Package irq_pkg SHALL hold NUM_SRC=3, the state encoding (IDLE/REQ/ISR), and the default vector constants.
REQ-032 One sub-module irq_prio_enc (3-bit vector -> valid + 2-bit highest index) SHALL be instantiated twice: for eligible and for in_service.

Verification
REQ-033 Scenario: after reset, irq_src=001, mask=111, disable=0. Required: pending=001 at +1 cycle; irq_req=1, id=0, vec=0x800 at +2; ack -> in_service=001, req=0; eret -> in_service=0, IDLE.
REQ-034 Scenario: src 001 and 100 rise in the same cycle. Required: id=2, vec=0x0; after ack, pending=001 remains.
REQ-035 Scenario: during REQ id=1, raise irq_disable. Required: irq_req=0 next cycle, pending=010 kept; lower disable -> REQ id=1 again.
REQ-036 Scenario: in ISR with in_service=001, source 2 edges. Required with IRQ_NEST_EN: REQ id=2, then in_service=101 after ack; eret -> 001. Required without IRQ_NEST_EN: pending=100, no req until eret.
REQ-037 Scenario: line held high at rst release. Required: no pending. Fall then rise -> pending set.
REQ-038 Scenario: ack cycle coincides with a new edge on the same source. Required: in_service bit set and pending bit still 1.
